// File: rtl/adder_pkg.sv
// Shared constants, stage-count helper and the per-stage register bundle
// for the carry-pipelined adder/subtractor.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;
  localparam int unsigned MAX_WIDTH     = 64;

  function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // Data fields are sized for the widest supported adder; bits above WIDTH stay zero.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH-1:0] d;
  } stage_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: adds operand slice K with the incoming carry and
// carries the remaining operand bits and finished sum slices forward.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK,
  parameter int unsigned K     = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv,
  input  stage_t prev,
  output stage_t cur
);

  localparam int unsigned LSB = K * CHUNK;

  if (LSB + CHUNK > WIDTH) begin : g_bad_slice
    $fatal(1, "adder_chunk_stage: slice %0d exceeds WIDTH", K);
  end

  logic [CHUNK-1:0]     a_c;
  logic [CHUNK-1:0]     b_c;
  logic [CHUNK-1:0]     s;
  logic [CHUNK:0]       sum;
  logic                 c_out;
  logic                 ovf;
  logic [MAX_WIDTH-1:0] d_next;
  logic                 unused_ovf;

  assign unused_ovf = prev.ovf;

  // Overflow here is only meaningful in the top slice: for the MSB full adder,
  // carry-in XOR carry-out equals "equal operand signs, different sum sign".
  always_comb begin
    a_c    = prev.a[LSB +: CHUNK];
    b_c    = prev.b[LSB +: CHUNK];
    sum    = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, prev.carry};
    s      = sum[CHUNK-1:0];
    c_out  = sum[CHUNK];
    ovf    = (a_c[CHUNK-1] == b_c[CHUNK-1]) && (s[CHUNK-1] != a_c[CHUNK-1]);
    d_next = prev.d;
    d_next[LSB +: CHUNK] = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (adv) begin
      cur.valid <= prev.valid;
      if (prev.valid) begin
        cur.carry <= c_out;
        cur.ovf   <= ovf;
        cur.a     <= prev.a;
        cur.b     <= prev.b;
        cur.d     <= d_next;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage,
// with valid/ready flow control and bubble-collapsing advance chain.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iSub,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oD,
  output logic             oCarry,
  output logic             oOverflow,
  output logic             oValid,
  input  logic             iReady
);

  localparam int unsigned STAGES = stages(WIDTH, CHUNK);

  if (CHUNK == 0) begin : g_bad_chunk
    $fatal(1, "pipelined_adder: CHUNK must be non-zero");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_ratio
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of CHUNK");
  end
  if (WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "pipelined_adder: WIDTH exceeds MAX_WIDTH");
  end

  stage_t stg_in [STAGES];
  stage_t stg    [STAGES];
  logic   adv    [STAGES];
  logic   unused_tail;

  // Subtraction is A + ~B + 1: invert B up front and feed iSub as the carry-in.
  always_comb begin
    stg_in[0]       = '0;
    stg_in[0].valid = iValid;
    stg_in[0].carry = iSub;
    stg_in[0].a     = MAX_WIDTH'(iA);
    stg_in[0].b     = MAX_WIDTH'(iSub ? ~iB : iB);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stg_in[k] = stg[k-1];
    end

    if (k == STAGES - 1) begin : g_adv_last
      assign adv[k] = !stg[k].valid || iReady;
    end else begin : g_adv_mid
      assign adv[k] = !stg[k].valid || adv[k+1];
    end

    adder_chunk_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .K    (k)
    ) u_stage (
      .clk  (iClk),
      .rst_n(iRstN),
      .adv  (adv[k]),
      .prev (stg_in[k]),
      .cur  (stg[k])
    );
  end

  assign oReady    = adv[0];
  assign oValid    = stg[STAGES-1].valid;
  assign oD        = stg[STAGES-1].d[WIDTH-1:0];
  assign oCarry    = stg[STAGES-1].carry;
  assign oOverflow = stg[STAGES-1].ovf;

  assign unused_tail = ^{stg[STAGES-1].a, stg[STAGES-1].b, stg[STAGES-1].d};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=16, CHUNK=4 (latency 4).
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int C = 4;

  logic         iClk = 1'b0;
  logic         iRstN;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iSub;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] oD;
  logic         oCarry;
  logic         oOverflow;
  logic         oValid;
  logic         iReady;

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iA       (iA),
    .iB       (iB),
    .iSub     (iSub),
    .iValid   (iValid),
    .oReady   (oReady),
    .oD       (oD),
    .oCarry   (oCarry),
    .oOverflow(oOverflow),
    .oValid   (oValid),
    .iReady   (iReady)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         o;
  } res_t;

  res_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion at %0t", name, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    int   ua = int'(a);
    int   ub = int'(b);
    int   sa;
    int   sb;
    int   sr;
    sa = $signed(a);
    sb = $signed(b);
    if (!sub) begin
      r.d = W'(ua + ub);
      r.c = (ua + ub) > 65535;
      sr  = sa + sb;
    end else begin
      r.d = W'(ua - ub);
      r.c = ua >= ub;
      sr  = sa - sb;
    end
    r.o = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic rdy, input res_t exp, output bit acc);
    @(negedge iClk);
    iValid = v; iA = a; iB = b; iSub = sub; iReady = rdy;
    #1;
    acc = v && oReady;
    if (acc) sbq.push_back(exp);
  endtask

  task automatic idle(input int n);
    bit   acc;
    res_t z;
    z = '{d: '0, c: 1'b0, o: 1'b0};
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, z, acc);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input res_t exp);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 50) begin
      tick(1'b1, a, b, sub, 1'b1, exp, acc);
      n++;
    end
    if (!acc) fail("send_timeout");
  endtask

  // Monitor: pops on each consume, and checks outputs hold while stalled.
  initial begin : monitor
    bit   held = 1'b0;
    res_t hv;
    res_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (!iRstN) begin
        held = 1'b0;
      end else if (oValid) begin
        if (held) begin
          cmp("hold_d", 32'(oD), 32'(hv.d));
          cmp("hold_carry", 32'(oCarry), 32'(hv.c));
          cmp("hold_ovf", 32'(oOverflow), 32'(hv.o));
        end
        if (iReady) begin
          if (sbq.size() == 0) begin
            fail("stale_valid");
          end else begin
            e = sbq.pop_front();
            cmp("result_d", 32'(oD), 32'(e.d));
            cmp("result_carry", 32'(oCarry), 32'(e.c));
            cmp("result_ovf", 32'(oOverflow), 32'(e.o));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv   = '{d: oD, c: oCarry, o: oOverflow};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [W-1:0] dir_a   [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000};
  logic [W-1:0] dir_b   [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
  logic         dir_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] dir_d   [6] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
  logic         dir_c   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic         dir_o   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin : driver
    bit           acc;
    int           sent;
    int           cyc;
    int           n;
    int           stale;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W-1:0] bp_a [8];
    logic [W-1:0] bp_b [8];
    logic         bp_s [8];

    iRstN = 1'b0; iValid = 1'b1; iReady = 1'b1; iA = 16'hAAAA; iB = 16'h5555; iSub = 1'b0;
    repeat (3) @(negedge iClk);
    #1;
    cmp("in_reset_valid", 32'(oValid), 32'd0);
    @(negedge iClk);
    iRstN = 1'b1; iValid = 1'b0;
    #1;
    cmp("reset_valid", 32'(oValid), 32'd0);
    cmp("reset_d", 32'(oD), 32'd0);
    cmp("reset_carry", 32'(oCarry), 32'd0);
    cmp("reset_ovf", 32'(oOverflow), 32'd0);
    cmp("reset_ready", 32'(oReady), 32'd1);

    // Directed vectors; the first also pins down the 4-stage latency.
    for (int i = 0; i < 6; i++) begin
      send(dir_a[i], dir_b[i], dir_sub[i], '{d: dir_d[i], c: dir_c[i], o: dir_o[i]});
      if (i == 0) begin
        for (int j = 1; j <= 4; j++) begin
          idle(1);
          cmp("latency_valid", 32'(oValid), (j == 4) ? 32'd1 : 32'd0);
        end
      end
      idle(6);
    end

    // Back-to-back with consumer stalled for cycles 3..7.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
      bp_s[i] = 1'($urandom);
    end
    sent = 0;
    cyc  = 0;
    while ((sent < 8 || cyc < 9) && cyc < 60) begin
      if (sent < 8)
        tick(1'b1, bp_a[sent], bp_b[sent], bp_s[sent], !(cyc >= 3 && cyc <= 7),
             model(bp_a[sent], bp_b[sent], bp_s[sent]), acc);
      else
        tick(1'b0, '0, '0, 1'b0, 1'b1, '{d: '0, c: 1'b0, o: 1'b0}, acc);
      if (cyc == 4) begin
        cmp("full_ready_low", 32'(oReady), 32'd0);
        cmp("accepted_at_full", 32'(sent), 32'd4);
      end
      if (cyc == 8) cmp("full_accept_on_drain", 32'(acc), 32'd1);
      if (acc) sent++;
      cyc++;
    end
    if (sent < 8) fail("backpressure_timeout");
    idle(8);

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
      tick($urandom_range(0, 3) != 0, ra, rb, rs, $urandom_range(0, 2) != 0, model(ra, rb, rs), acc);
    end
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    if (sbq.size() != 0) fail("drain_timeout");
    idle(4);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      tick(1'b1, ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0), acc);
    end
    @(negedge iClk);
    iRstN = 1'b0; iValid = 1'b1;
    #1;
    sbq.delete();
    cmp("midrst_valid", 32'(oValid), 32'd0);
    cmp("midrst_d", 32'(oD), 32'd0);
    cmp("midrst_ready", 32'(oReady), 32'd1);
    repeat (2) @(negedge iClk);
    iRstN = 1'b1; iValid = 1'b0; iReady = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      #1;
      if (oValid) stale++;
    end
    cmp("post_reset_no_stale", 32'(stale), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
